fetch_stage: RTL

- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of decode.
- Owns the PC register and a single-outstanding request/response interface to instruction memory.
- Owns the IF/ID pipeline register that drives decode's ins, pc_d_i and pc_plus_4d_i inputs.
- Honours hazard-unit stall/flush and execute-stage redirects (branch/jump).

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/if_id_reg.sv | 42 ++++
 rtl/fetch_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants.
// Imported by every pipeline stage.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INS  = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush > stall > load > bubble.
// Same shape is reused for the ID/EX register.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INS
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush_i,
  input  logic   stall_i,
  input  logic   load_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  localparam if_id_t BUBBLE = '{
    ins:       NOP,
    pc:        '0,
    pc_plus_4: '0,
    valid:     1'b0
  };

  if_id_t q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= BUBBLE;
    end else if (flush_i) begin
      q_q <= BUBBLE;
    end else if (stall_i) begin
      q_q <= q_q;
    end else if (load_i) begin
      q_q <= d_i;
    end else begin
      q_q <= BUBBLE;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, single-outstanding imem
// handshake, response buffer and IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int                     DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC   = riscv_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0]  NOP_INS    = riscv_pkg::NOP_INS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_src_e,
  input  logic [DATA_WIDTH-1:0] pc_target_e,
  input  logic                  stall_d,
  input  logic                  flush_d,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] ins_d,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pc_plus_4d,
  output logic                  valid_d,
  output logic                  busy_f
);

  localparam logic [DATA_WIDTH-1:0] FOUR = 4;
  localparam logic [DATA_WIDTH-1:0] LOW2 = 3;

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_f_q, pc_f_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  kill_q, kill_d;

  logic                  deliver;
  logic [DATA_WIDTH-1:0] fetch_ins;
  logic [DATA_WIDTH-1:0] pc_plus_4_f;
  logic [DATA_WIDTH-1:0] target;
  if_id_t                ifid_in;
  if_id_t                ifid_q;

  assign pc_plus_4_f = pc_f_q + FOUR;
  assign target      = pc_target_e & ~LOW2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_f_q  <= RESET_PC;
      buf_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_f_q  <= pc_f_d;
      buf_q   <= buf_d;
      kill_q  <= kill_d;
    end
  end

  // Redirect overrides every fetch-side transition.
  always_comb begin
    state_d = state_q;
    pc_f_d  = pc_f_q;
    buf_d   = buf_q;
    kill_d  = kill_q;
    if (deliver) pc_f_d = pc_plus_4_f;
    unique case (state_q)
      IDLE: begin
        state_d = WAIT;
        kill_d  = pc_src_e;
      end
      WAIT: begin
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (pc_src_e || kill_q || !stall_d) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            buf_d   = imem_rdata;
          end
        end else if (pc_src_e) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (pc_src_e || !stall_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pc_src_e) pc_f_d = target;
  end

  always_comb begin
    imem_req  = 1'b0;
    busy_f    = 1'b0;
    deliver   = 1'b0;
    fetch_ins = imem_rdata;
    unique case (state_q)
      IDLE: imem_req = !rst;
      WAIT: begin
        busy_f  = 1'b1;
        deliver = imem_rvalid && !kill_q
                  && !stall_d && !pc_src_e;
      end
      HOLD: begin
        deliver   = !stall_d && !pc_src_e;
        fetch_ins = buf_q;
      end
      default: ;
    endcase
  end

  assign imem_addr = pc_f_q;

  assign ifid_in = '{
    ins:       fetch_ins,
    pc:        pc_f_q,
    pc_plus_4: pc_plus_4_f,
    valid:     1'b1
  };

  if_id_reg #(
    .NOP (NOP_INS)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_d),
    .stall_i (stall_d),
    .load_i  (deliver),
    .d_i     (ifid_in),
    .q_o     (ifid_q)
  );

  assign ins_d      = ifid_q.ins;
  assign pc_d       = ifid_q.pc;
  assign pc_plus_4d = ifid_q.pc_plus_4;
  assign valid_d    = ifid_q.valid;

endmodule
